// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - RV32I opcode/func constants shared by the operand stage
package alu_operand_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Sign-extended I-type immediate
    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
        return {{(XLEN-12){instr[31]}}, instr[31:20]};
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - instruction, writeback and operand channels of the operand stage
interface alu_operand_stage_if;
    import alu_operand_stage_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_in1;
    logic [XLEN-1:0] out_in2;
    logic [2:0]      out_func3;
    logic            out_opequal;
    logic [4:0]      out_rd;
    logic            out_rd_we;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, wb_we, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_in1, out_in2, out_func3,
               out_opequal, out_rd, out_rd_we, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, wb_we, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_in1, out_in2, out_func3,
               out_opequal, out_rd, out_rd_we, out_illegal
    );
endinterface

// File: rtl/alu_operand_stage_regfile_2r1w.sv
// rtl/alu_operand_stage_regfile_2r1w.sv - 2-read 1-write register file, x0 hardwired, optional ALU_OPERAND_BYPASS_EN write-through
module regfile_2r1w
    import alu_operand_stage_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_ok;

    // Index 0 and indices beyond the implemented file never hold state
    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NREGS);
    endfunction

    assign wr_ok = we_i && addr_ok(waddr_i);

    // Storage: reset clears everything and wins over a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    // Asynchronous reads; the bypass build forwards a same-cycle write
    always_comb begin
        rdata1_o = addr_ok(raddr1_i) ? regs_q[raddr1_i[AW-1:0]] : '0;
        rdata2_o = addr_ok(raddr2_i) ? regs_q[raddr2_i[AW-1:0]] : '0;
`ifdef ALU_OPERAND_BYPASS_EN
        if (wr_ok && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
        if (wr_ok && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`endif
    end
endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - RV32I OP/OP-IMM decode and operand register; ALU_OPERAND_BYPASS_EN enables regfile write-through
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                clk,
    input  logic                rst,
    alu_operand_stage_if.slave  bus
);
    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            legal, is_op, load;

    logic [XLEN-1:0] in1_d, in2_d;
    logic            opequal_d, rd_we_d;

    logic            valid_q, opequal_q, rd_we_q, illegal_q;
    logic [XLEN-1:0] in1_q, in2_q;
    logic [2:0]      func3_q;
    logic [4:0]      rd_q;

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign f3     = bus.in_instr[14:12];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];
    assign f7     = bus.in_instr[31:25];

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready;

    regfile_2r1w #(.NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (bus.wb_we),
        .waddr_i  (bus.wb_rd),
        .wdata_i  (bus.wb_data),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1_val),
        .rdata2_o (rs2_val)
    );

    // Decode: legality, operand selection and qualifier; illegal encodings zero the operands
    always_comb begin
        legal     = 1'b0;
        is_op     = 1'b0;
        opequal_d = 1'b0;
        in1_d     = rs1_val;
        in2_d     = imm_i(bus.in_instr);
        case (opcode)
            OPC_OP: begin
                is_op     = 1'b1;
                in2_d     = rs2_val;
                opequal_d = f7[5];
                legal     = (f7 == F7_BASE) ||
                            ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL)));
            end
            OPC_OP_IMM: begin
                case (f3)
                    F3_SLL: legal = (f7 == F7_BASE);
                    F3_SRL: begin
                        legal     = (f7 == F7_BASE) || (f7 == F7_ALT);
                        opequal_d = f7[5];
                    end
                    default: legal = 1'b1;
                endcase
            end
            default: legal = 1'b0;
        endcase
        // RV32E has no x16..x31; OP-IMM has no rs2 field to check
        if ((NREGS == 16) && (rs1[4] || rd[4] || (is_op && rs2[4]))) legal = 1'b0;
        if (!legal) begin
            in1_d     = '0;
            in2_d     = '0;
            opequal_d = 1'b0;
        end
        rd_we_d = legal && (rd != 5'd0);
    end

    // Output register: loads on transfer, holds under backpressure, drains when accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            in1_q     <= '0;
            in2_q     <= '0;
            func3_q   <= '0;
            opequal_q <= 1'b0;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (load) begin
            valid_q   <= 1'b1;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            func3_q   <= f3;
            opequal_q <= opequal_d;
            rd_q      <= rd;
            rd_we_q   <= rd_we_d;
            illegal_q <= !legal;
        end else if (bus.out_ready) begin
            valid_q   <= 1'b0;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_in1     = in1_q;
    assign bus.out_in2     = in2_q;
    assign bus.out_func3   = func3_q;
    assign bus.out_opequal = opequal_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_rd_we   = rd_we_q;
    assign bus.out_illegal = illegal_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed self-checking bench for alu_operand_stage
module tb_alu_operand_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [75:0] obs;
    logic [75:0] exp_v;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {valid, in1, in2, func3, opequal, rd, rd_we, illegal}
    function automatic logic [75:0] snap();
        return {bus.out_valid, bus.out_in1, bus.out_in2, bus.out_func3,
                bus.out_opequal, bus.out_rd, bus.out_rd_we, bus.out_illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr);
        bus.in_valid  = 1'b1;
        bus.in_instr  = instr;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        obs = snap();
        if (obs !== 76'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 76'd0);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_sub();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
        tick();
        bus.wb_rd = 5'd2; bus.wb_data = 32'd3;
        tick();
        bus.wb_we = 1'b0;
        issue(32'h402081B3);
        checks++;
        obs = snap();
        exp_v = {1'b1, 32'd5, 32'd3, 3'b000, 1'b1, 5'd3, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL sub_x3_x1_x2: got %h expected %h", obs, exp_v);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sub_drain_valid: got %b expected 0", bus.out_valid);
        end
        issue(32'h00208033);
        checks++;
        obs = snap();
        exp_v = {1'b1, 32'd5, 32'd3, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL add_rd0: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_imm();
        issue(32'hFFF00213);
        checks++;
        obs = snap();
        exp_v = {1'b1, 32'd0, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd4, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL addi_neg1: got %h expected %h", obs, exp_v);
        end
        issue(32'h4030D293);
        checks++;
        obs = snap();
        exp_v = {1'b1, 32'd5, 32'h403, 3'b101, 1'b1, 5'd5, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL srai: got %h expected %h", obs, exp_v);
        end
        issue(32'h40309293);
        checks++;
        obs = snap();
        exp_v = {1'b1, 32'd0, 32'd0, 3'b001, 1'b0, 5'd5, 1'b0, 1'b1};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL slli_alt_illegal: got %h expected %h", obs, exp_v);
        end
        issue(32'h00000000);
        checks++;
        obs = snap();
        exp_v = {1'b1, 32'd0, 32'd0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b1};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bad_opcode_illegal: got %h expected %h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00100393;
        tick();
        bus.in_instr  = 32'h00200413;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
            end
            checks++;
            obs = snap();
            exp_v = {1'b1, 32'd0, 32'd1, 3'b000, 1'b0, 5'd7, 1'b1, 1'b0};
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, exp_v);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %b expected 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        obs = snap();
        exp_v = {1'b1, 32'd0, 32'd2, 3'b000, 1'b0, 5'd8, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL release_next: got %h expected %h", obs, exp_v);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_duplicate: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_in1;
`ifdef ALU_OPERAND_BYPASS_EN
        exp_in1 = 32'hDEAD;
`else
        exp_in1 = 32'd5;
`endif
        bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'hDEAD;
        bus.in_valid = 1'b1; bus.in_instr = 32'h00008333; bus.out_ready = 1'b1;
        tick();
        bus.wb_we = 1'b0;
        checks++;
        if (bus.out_in1 !== exp_in1) begin
            errors++;
            $display("FAIL same_cycle_wb_in1: got %h expected %h", bus.out_in1, exp_in1);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_in1 !== 32'hDEAD) begin
            errors++;
            $display("FAIL after_wb_in1: got %h expected %h", bus.out_in1, 32'hDEAD);
        end
        tick();
    endtask

    task automatic test_x0();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h1234;
        tick();
        bus.wb_we = 1'b0;
        issue(32'h000004B3);
        checks++;
        obs = snap();
        exp_v = {1'b1, 32'd0, 32'd0, 3'b000, 1'b0, 5'd9, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL x0_read: got %h expected %h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00208533;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pending_valid: got %b expected 1", bus.out_valid);
        end
        rst = 1'b1;
        bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'd77;
        tick();
        rst = 1'b0;
        bus.wb_we = 1'b0;
        checks++;
        obs = snap();
        if (obs !== 76'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h expected %h", obs, 76'd0);
        end
        issue(32'h003085B3);
        checks++;
        obs = snap();
        exp_v = {1'b1, 32'd0, 32'd0, 3'b000, 1'b0, 5'd11, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL regs_cleared: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.wb_we     = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_sub();
        test_imm();
        test_back_to_back();
        test_bypass();
        test_x0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
